fsk_tx_modulator: RTL

Binary FSK transmitter that is the sending end of the FSK link demodulated by the receiver's frequency detector. A parallel data word is accepted through a valid/ready handshake. The block then serialises a frame as a square wave on `fsk_out`: a run of '0' symbols for frequency acquisition, one '1' start symbol, then the data bits MSB first. It runs on the 200 MHz PLL clock, and its output drives the channel (or the receiver input in loopback simulation).

---
 rtl/fsk_tx_modulator_if.sv | 21 ++
 rtl/fsk_tx_modulator.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/fsk_tx_modulator_if.sv
// fsk_tx_modulator_if
//   Word-transfer channel into the FSK transmitter.
//   Valid/ready semantics: the master drives data_in/data_valid, the slave
//   drives data_ready. A word is transferred on a rising clk edge where both
//   data_valid and data_ready are high. data_ready does not depend on
//   data_valid. The master keeps data_valid and data_in stable until that
//   transfer edge.
//   Signals:
//     data_in    [NBITS-1:0]  word to transmit (master -> slave)
//     data_valid              data_in is valid (master -> slave)
//     data_ready              slave can take a word this cycle (slave -> master)
interface fsk_tx_modulator_if #(
    parameter int NBITS = 12
);
    logic [NBITS-1:0] data_in;
    logic             data_valid;
    logic             data_ready;

    modport master (output data_in, output data_valid, input data_ready);
    modport slave  (input data_in, input data_valid, output data_ready);
endinterface

// File: rtl/fsk_tx_modulator.sv
// fsk_tx_modulator
//   Binary FSK transmitter. A word taken from in_if is sent as a frame of
//   PREAMBLE_BITS '0' symbols, one '1' start symbol, then NBITS data bits
//   MSB first. Every symbol lasts BIT_CYCLES clocks. fsk_out is a
//   phase-continuous square wave whose half-period is HALF0 clocks for '0'
//   and HALF1 clocks for '1'.
//   Optional feature: define FSK_TX_STREAM_EN to accept the next word in
//   the final cycle of a frame. That word is then sent straight as DATA
//   symbols, with no preamble and no sync, and the tone phase continues.
//   Ports:
//     clk, rst_n   clock and asynchronous active-low reset
//     in_if        slave side of the word handshake (data_in/valid/ready)
//     fsk_out      modulated square wave (0 when idle)
//     bit_out      symbol currently being sent (0 when idle)
//     busy         a frame is in progress
//     frame_done   pulse in the final cycle of the last data bit
//     state_dbg    current FSM state (0 idle, 1 preamble, 2 sync, 3 data)
module fsk_tx_modulator #(
    parameter int NBITS         = 12,
    parameter int BIT_CYCLES    = 2000,
    parameter int HALF0         = 100,
    parameter int HALF1         = 50,
    parameter int PREAMBLE_BITS = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    fsk_tx_modulator_if.slave   in_if,
    output logic                fsk_out,
    output logic                bit_out,
    output logic                busy,
    output logic                frame_done,
    output logic [1:0]          state_dbg
);
    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_PREAMBLE = 2'd1,
        S_SYNC     = 2'd2,
        S_DATA     = 2'd3
    } state_e;

    localparam logic [15:0] BIT_LAST  = 16'(BIT_CYCLES - 1);
    localparam logic [15:0] H0_LAST   = 16'(HALF0 - 1);
    localparam logic [15:0] H1_LAST   = 16'(HALF1 - 1);
    localparam logic [15:0] PRE_LAST  = 16'(PREAMBLE_BITS - 1);
    localparam logic [15:0] DATA_LAST = 16'(NBITS - 1);

    state_e           state_q, state_d;
    logic [15:0]      bt_q, bt_d;      // bit timer, 0..BIT_CYCLES-1
    logic [15:0]      sym_q, sym_d;    // symbol index within the current state
    logic [15:0]      hc_q, hc_d;      // half-period counter of the tone
    logic [NBITS-1:0] sr_q, sr_d;      // data shift register, MSB goes out first
    logic             fsk_q, fsk_d;

    logic             bit_wrap;
    logic             ready_w;
    logic             accept;
    logic [15:0]      h_last;

    assign in_if.data_ready = ready_w;
    assign fsk_out          = fsk_q;
    assign busy             = (state_q != S_IDLE);
    assign state_dbg        = state_q;

    always_comb begin
        bit_wrap = (bt_q == BIT_LAST);

        case (state_q)
            S_SYNC:  bit_out = 1'b1;
            S_DATA:  bit_out = sr_q[NBITS-1];
            default: bit_out = 1'b0;
        endcase

        frame_done = (state_q == S_DATA) && bit_wrap && (sym_q == DATA_LAST);
`ifdef FSK_TX_STREAM_EN
        ready_w = (state_q == S_IDLE) || frame_done;
`else
        ready_w = (state_q == S_IDLE);
`endif
        accept = in_if.data_valid && ready_w;

        h_last  = bit_out ? H1_LAST : H0_LAST;

        state_d = state_q;
        bt_d    = bt_q;
        sym_d   = sym_q;
        hc_d    = hc_q;
        sr_d    = sr_q;
        fsk_d   = fsk_q;

        // Tone and bit timer run in every non-idle cycle. The >= compare
        // keeps the tone phase-continuous: when the symbol switches to a
        // shorter half-period and hc is already past the new terminal value,
        // fsk_out toggles on the very next cycle.
        if (state_q != S_IDLE) begin
            if (hc_q >= h_last) begin
                fsk_d = ~fsk_q;
                hc_d  = 16'd0;
            end else begin
                hc_d  = hc_q + 16'd1;
            end
            bt_d = bit_wrap ? 16'd0 : bt_q + 16'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_PREAMBLE;
                    bt_d    = 16'd0;
                    sym_d   = 16'd0;
                    hc_d    = 16'd0;
                    fsk_d   = 1'b0;
                    sr_d    = in_if.data_in;
                end
            end
            S_PREAMBLE: begin
                if (bit_wrap) begin
                    if (sym_q == PRE_LAST) begin
                        state_d = S_SYNC;
                        sym_d   = 16'd0;
                    end else begin
                        sym_d   = sym_q + 16'd1;
                    end
                end
            end
            S_SYNC: begin
                if (bit_wrap) begin
                    state_d = S_DATA;
                    sym_d   = 16'd0;
                end
            end
            S_DATA: begin
                if (bit_wrap) begin
                    if (sym_q == DATA_LAST) begin
                        // accept can only be high here in the streaming
                        // build: the new word continues as DATA, tone intact.
                        if (accept) begin
                            sr_d  = in_if.data_in;
                            sym_d = 16'd0;
                        end else begin
                            state_d = S_IDLE;
                            sym_d   = 16'd0;
                            hc_d    = 16'd0;
                            fsk_d   = 1'b0;
                        end
                    end else begin
                        sr_d  = sr_q << 1;
                        sym_d = sym_q + 16'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            bt_q    <= 16'd0;
            sym_q   <= 16'd0;
            hc_q    <= 16'd0;
            sr_q    <= '0;
            fsk_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bt_q    <= bt_d;
            sym_q   <= sym_d;
            hc_q    <= hc_d;
            sr_q    <= sr_d;
            fsk_q   <= fsk_d;
        end
    end
endmodule
